// File: rtl/dram_pkg.sv
// Shared types for the clocked data RAM: access-size encodings, FSM state
// encoding and the byte count of each access size.
package dram_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WAIT   = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    // Number of bytes touched by an access; the reserved size is flagged as an
    // error elsewhere, so its count only has to be harmless.
    function automatic logic [2:0] size_bytes(input size_e size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_sync_if.sv
// Request/response port of the clocked data RAM. The MEM stage is the master,
// the RAM is the slave.
interface data_ram_sync_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dram_load_align.sv
// Picks the addressed byte/halfword out of a fetched big-endian word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module dram_load_align
    import dram_pkg::*;
(
    input  logic [31:0] word_i,   // byte at offset 0 sits in [31:24]
    input  logic [1:0]  offs_i,   // addr[1:0]
    input  size_e       size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension to 32 bits.
    always_comb begin
        case (offs_i)
            2'd0:    byte_sel = word_i[31:24];
            2'd1:    byte_sel = word_i[23:16];
            2'd2:    byte_sel = word_i[15:8];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = offs_i[1] ? word_i[15:0] : word_i[31:16];
        data_o   = '0;
        case (size_i)
            SZ_BYTE: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
            SZ_WORD: data_o = word_i;
            default: data_o = '0;
        endcase
    end
endmodule

// File: rtl/data_ram_sync.sv
// Clocked byte-addressed big-endian data RAM with a single-outstanding
// valid/ready request port and a registered one-cycle response.
// Optional macro DRAM_WAIT_EN inserts WAIT_CYCLES stall cycles per access.
module data_ram_sync
    import dram_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    data_ram_sync_if.slave   bus_io
);
    localparam int AW = $clog2(DEPTH_BYTES);

    logic [7:0] mem [0:DEPTH_BYTES-1];

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    size_e             size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    logic [31:0]       fetch_q;
    logic [31:0]       load_val;
    logic              misalign, out_of_range, err;
    logic [AW-1:0]     word_base;
    logic [3:0]        lane_we;
    logic [7:0]        lane_data [4];

`ifdef DRAM_WAIT_EN
    logic [3:0]        wait_cnt_q, wait_cnt_d;
`else
    logic              unused_wait;
    assign unused_wait = ^4'(WAIT_CYCLES);
`endif

    // Error decode works on the captured request, so it is stable from
    // ACCESS through RESP. Addresses never wrap: any byte past the end errors.
    assign misalign     = (size_q == SZ_HALF && addr_q[0]) ||
                          (size_q == SZ_WORD && addr_q[1:0] != 2'b00);
    assign out_of_range = ({1'b0, addr_q} + (ADDR_W+1)'(size_bytes(size_q)))
                          > (ADDR_W+1)'(DEPTH_BYTES);
    assign err          = misalign || out_of_range || (size_q == SZ_RSVD);

    // Accesses are aligned, so every access lives inside one aligned word.
    assign word_base = addr_q[AW-1:0] & ~AW'(3);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_we[gi] = (state_q == ST_ACCESS) && we_q && !err &&
                                 ((size_q == SZ_BYTE && addr_q[1:0] == LANE) ||
                                  (size_q == SZ_HALF && addr_q[1] == LANE[1]) ||
                                  (size_q == SZ_WORD));
            // Big-endian: the lowest lane takes the most significant store byte.
            assign lane_data[gi] = (size_q == SZ_WORD) ? wdata_q[31-8*gi -: 8] :
                                   (size_q == SZ_HALF && !LANE[0]) ? wdata_q[15:8] :
                                   wdata_q[7:0];
        end
    endgenerate

    // Storage: lane writes and a registered word fetch, both in ACCESS.
    always_ff @(posedge clk) begin
        if (state_q == ST_ACCESS) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_we[k]) begin
                    mem[word_base | AW'(k)] <= lane_data[k];
                end
                fetch_q[31-8*k -: 8] <= mem[word_base | AW'(k)];
            end
        end
    end

    dram_load_align u_align (
        .word_i   (fetch_q),
        .offs_i   (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (sgn_q),
        .data_o   (load_val)
    );

    // Control and request registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            sgn_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef DRAM_WAIT_EN
    // Stall counter for the WAIT state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    // Next-state, request capture and response generation.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
`ifdef DRAM_WAIT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus_io.req_valid && ready_q) begin
                    state_d = ST_ACCESS;
                    we_d    = bus_io.req_we;
                    size_d  = size_e'(bus_io.req_size);
                    sgn_d   = bus_io.req_signed;
                    addr_d  = bus_io.req_addr;
                    wdata_d = bus_io.req_wdata;
                end
            end
            ST_ACCESS: begin
`ifdef DRAM_WAIT_EN
                if (WAIT_CYCLES != 0) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 4'(WAIT_CYCLES - 1);
                end else begin
                    state_d = ST_RESP;
                end
`else
                state_d = ST_RESP;
`endif
            end
            ST_WAIT: begin
`ifdef DRAM_WAIT_EN
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = err;
                rsp_rdata_d = (err || we_q) ? '0 : load_val;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    assign bus_io.req_ready = ready_q;
    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_rdata = rsp_rdata_q;
    assign bus_io.rsp_err   = rsp_err_q;

endmodule
